// File: rtl/bcd_display_scanner.sv
// Snapshots N packed BCD digits, converts them to 7-segment patterns and shifts
// the frame out serially with a trailing latch pulse. BCD_SCAN_DP_EN adds a decimal point bit.
module bcd_display_scanner #(
   parameter int NUM_DIGITS = 6,
   parameter int SCLK_HALF  = 1,
   parameter int LZ_BLANK   = 0
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_en,
   input  logic                      i_refresh,
   input  logic [4*NUM_DIGITS-1:0]   i_digits,
   input  logic [NUM_DIGITS-1:0]     i_blank_mask,
`ifdef BCD_SCAN_DP_EN
   input  logic [NUM_DIGITS-1:0]     i_dp_mask,
`endif
   output logic                      o_sdata,
   output logic                      o_sclk,
   output logic                      o_latch,
   output logic                      o_busy,
   output logic                      o_done
);

`ifdef BCD_SCAN_DP_EN
   localparam int SEG_BITS = 8;
`else
   localparam int SEG_BITS = 7;
`endif
   localparam int FRAME_BITS = NUM_DIGITS * SEG_BITS;
   localparam int BIT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [7:0]       HC_LAST  = 8'(SCLK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;

   state_t                  state_q;
   logic [FRAME_BITS-1:0]   sr_q;
   logic [FRAME_BITS-1:0]   frame_d;
   logic [7:0]              hcnt_q;
   logic [BIT_W-1:0]        bit_q;
   logic                    sdata_q, sclk_q, latch_q, busy_q, done_q;
   logic [NUM_DIGITS-1:0]   lz_w, kill_w;
   logic                    lead_w;
   logic [6:0]              seg_w;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: seg7 = 7'h3F;
         4'd1: seg7 = 7'h06;
         4'd2: seg7 = 7'h5B;
         4'd3: seg7 = 7'h4F;
         4'd4: seg7 = 7'h66;
         4'd5: seg7 = 7'h6D;
         4'd6: seg7 = 7'h7D;
         4'd7: seg7 = 7'h07;
         4'd8: seg7 = 7'h7F;
         4'd9: seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   // Frame image built from the live inputs; it is captured only in LOAD.
   always_comb begin
      lead_w  = 1'b1;
      lz_w    = '0;
      kill_w  = '0;
      seg_w   = '0;
      frame_d = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (i_digits[4*k +: 4] != 4'd0) lead_w = 1'b0;
         lz_w[k] = lead_w && (LZ_BLANK != 0);
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
         kill_w[k] = i_blank_mask[k] | ~i_en;
         seg_w = (kill_w[k] | lz_w[k]) ? 7'h00 : seg7(i_digits[4*k +: 4]);
         frame_d[k*SEG_BITS +: 7] = seg_w;
`ifdef BCD_SCAN_DP_EN
         frame_d[k*SEG_BITS + 7] = i_dp_mask[k] & ~kill_w[k];
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         sr_q    <= '0;
         hcnt_q  <= '0;
         bit_q   <= '0;
         sdata_q <= 1'b0;
         sclk_q  <= 1'b0;
         latch_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (i_refresh) begin
               state_q <= LOAD;
               busy_q  <= 1'b1;
            end
            LOAD: begin
               sr_q    <= frame_d << 1;
               sdata_q <= frame_d[FRAME_BITS-1];
               hcnt_q  <= '0;
               bit_q   <= '0;
               sclk_q  <= 1'b0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (hcnt_q == HC_LAST) begin
                  hcnt_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     // Falling edge closes one bit; data only changes while sclk is low.
                     sclk_q <= 1'b0;
                     if (bit_q == BIT_LAST) begin
                        state_q <= LATCH;
                        latch_q <= 1'b1;
                        sdata_q <= 1'b0;
                     end else begin
                        bit_q   <= bit_q + 1'b1;
                        sdata_q <= sr_q[FRAME_BITS-1];
                        sr_q    <= sr_q << 1;
                     end
                  end
               end else begin
                  hcnt_q <= hcnt_q + 8'd1;
               end
            end
            LATCH: begin
               if (hcnt_q == HC_LAST) begin
                  hcnt_q  <= '0;
                  latch_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  hcnt_q <= hcnt_q + 8'd1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_sdata = sdata_q;
   assign o_sclk  = sclk_q;
   assign o_latch = latch_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench: three scanner instances (default, LZ blanking, SCLK_HALF=3) checked
// against a digit-level reference model by decoding the serial stream.
module tb_bcd_display_scanner;

`ifdef BCD_SCAN_DP_EN
   localparam int SB = 8;
`else
   localparam int SB = 7;
`endif
   localparam int FB = 6 * SB;
   localparam logic [7:0] SEG [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [2:0]  refr = '0;
   logic [23:0] digits = '0;
   logic [5:0]  mask = '0;
   logic [2:0]  sdata, sclk, latch, busy, done;
   int          nchk = 0;
   int          nerr = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bcd_display_scanner #(
         .NUM_DIGITS(6), .SCLK_HALF(g == 2 ? 3 : 1), .LZ_BLANK(g == 1 ? 1 : 0)
      ) u_dut (
         .i_clk(clk), .i_reset(rst), .i_en(en), .i_refresh(refr[g]),
         .i_digits(digits), .i_blank_mask(mask),
`ifdef BCD_SCAN_DP_EN
         .i_dp_mask(6'd0),
`endif
         .o_sdata(sdata[g]), .o_sclk(sclk[g]), .o_latch(latch[g]),
         .o_busy(busy[g]), .o_done(done[g])
      );
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: highest nonzero digit bounds LZ blanking; frame is top digit first.
   function automatic logic [63:0] model(input logic [23:0] d, input logic [5:0] m,
                                         input bit e, input bit lz);
      int top = 0;
      logic [63:0] f = '0;
      for (int k = 0; k < 6; k++) if (d[4*k +: 4] != 4'd0) top = k;
      for (int k = 5; k >= 0; k--) begin
         logic [7:0] v;
         v = (!e || m[k] || (lz && k > top)) ? 8'h00 : SEG[d[4*k +: 4]];
         f = (f << SB) | 64'(v);
      end
      return f;
   endfunction

   task automatic run_frame(input int inst, input bit mid, input string tag);
      int h = (inst == 2) ? 3 : 1;
      logic [63:0] exp = model(digits, mask, en, inst == 1);
      logic [63:0] cap = '0;
      int nbits = 0, busy_cyc = 0, latch_cyc = 0, latch_rise = 0, done_cyc = 0;
      int hi_run = 0, lo_run = 0, extra_busy = 0;
      bit lo_valid = 0, bad_hi = 0, bad_lo = 0, bad_stab = 0, bad_lat = 0;
      bit seen = 0, fin = 0, mid_done = 0, ps = 0, pl = 0, capbit = 0;
      @(negedge clk) refr[inst] = 1'b1;
      @(negedge clk) refr[inst] = 1'b0;
      for (int c = 0; c < 4000 && !fin; c++) begin
         if (busy[inst]) begin busy_cyc++; seen = 1; end
         else if (seen) fin = 1;
         if (done[inst]) done_cyc++;
         if (latch[inst]) begin
            latch_cyc++;
            if (sdata[inst] || sclk[inst]) bad_lat = 1;
         end
         if (latch[inst] && !pl) latch_rise++;
         if (sclk[inst] && !ps) begin
            cap = (cap << 1) | 64'(sdata[inst]);
            nbits++;
            if (lo_valid && lo_run != h) bad_lo = 1;
            hi_run = 1;
            capbit = sdata[inst];
         end else if (sclk[inst]) begin
            hi_run++;
            if (sdata[inst] != capbit) bad_stab = 1;
         end else if (ps) begin
            if (hi_run != h) bad_hi = 1;
            lo_run = 1;
            lo_valid = 1;
         end else begin
            lo_run++;
         end
         ps = sclk[inst];
         pl = latch[inst];
         refr[inst] = 1'b0;
         if (mid && !mid_done && nbits == 10) begin
            refr[inst] = 1'b1;
            digits = $urandom;
            mid_done = 1;
         end
         if (!fin) @(negedge clk);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (busy[inst] || done[inst]) extra_busy++;
      end
      chk({tag, ".finished"}, 64'(fin), 64'd1);
      chk({tag, ".nbits"}, 64'(nbits), 64'(FB));
      chk({tag, ".frame"}, cap, exp);
      chk({tag, ".busy_cyc"}, 64'(busy_cyc), 64'(1 + 2*h*FB + h + 1));
      chk({tag, ".latch_w"}, 64'(latch_cyc), 64'(h));
      chk({tag, ".latch_n"}, 64'(latch_rise), 64'd1);
      chk({tag, ".done_n"}, 64'(done_cyc), 64'd1);
      chk({tag, ".timing"}, {60'd0, bad_hi, bad_lo, bad_stab, bad_lat}, 64'd0);
      chk({tag, ".idle_after"}, 64'(extra_busy), 64'd0);
   endtask

   initial begin
      int bad;
      logic [63:0] basic;
      int rises;
      repeat (3) @(negedge clk);
      chk("reset.out", {59'd0, sdata, sclk, latch, busy, done} & 64'h7FFF, 64'd0);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if ((sdata | sclk | latch | busy | done) != 3'b000) bad++;
      end
      chk("reset.idle", 64'(bad), 64'd0);

      // Basic frame with explicit expected patterns.
      digits = 24'h123456; mask = '0; en = 1'b1;
      basic = '0;
      foreach (SEG[i]) if (i >= 1 && i <= 6) basic = (basic << SB) | 64'(SEG[i]);
      run_frame(0, 0, "basic");
      chk("basic.expl", model(24'h123456, 6'd0, 1'b1, 1'b0), basic);

      digits = 24'h000705; mask = 6'b000100;
      run_frame(1, 0, "lzmask");
      digits = 24'h000000; mask = '0;
      run_frame(1, 0, "lzzero");
      digits = 24'hA0F009;
      run_frame(0, 0, "invalid");
      en = 1'b0;
      run_frame(0, 0, "disable");
      en = 1'b1;
      digits = 24'h987654;
      run_frame(2, 1, "collide");

      // Abort mid-shift: reset must clear outputs at once and suppress latch/done.
      digits = 24'h314159;
      @(negedge clk) refr[0] = 1'b1;
      @(negedge clk) refr[0] = 1'b0;
      rises = 0;
      for (int c = 0; c < 500 && rises < 21; c++) begin
         @(posedge clk); #1;
         if (sclk[0]) rises++;
      end
      chk("abort.reached", 64'(rises), 64'd21);
      #1 rst = 1'b1;
      #1 chk("abort.clear", {59'd0, sdata[0], sclk[0], latch[0], busy[0], done[0]}, 64'd0);
      bad = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (latch[0] || done[0] || busy[0]) bad++;
      end
      chk("abort.quiet", 64'(bad), 64'd0);
      run_frame(0, 0, "after_abort");

      // Randomised frames with zero-biased digits to exercise blanking.
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < 6; k++)
            digits[4*k +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
         mask = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
         en = ($urandom_range(0, 5) != 0);
         run_frame(n % 2, 0, $sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
